// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare, iterative MUL/DIV/MOD.
// Iterative datapath is built only when ALU_MULDIV_EN is defined.
module alu_mc #(
    parameter int WIDTH  = 8,
    parameter int IWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IWIDTH-1:0] op_code,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic              cf,
    output logic              zf,
    output logic              err
);

    localparam logic [IWIDTH-1:0] OP_AND = IWIDTH'('h00);
    localparam logic [IWIDTH-1:0] OP_ANDN = IWIDTH'('h01);
    localparam logic [IWIDTH-1:0] OP_OR = IWIDTH'('h02);
    localparam logic [IWIDTH-1:0] OP_ORN = IWIDTH'('h03);
    localparam logic [IWIDTH-1:0] OP_XOR = IWIDTH'('h04);
    localparam logic [IWIDTH-1:0] OP_XORN = IWIDTH'('h05);
    localparam logic [IWIDTH-1:0] OP_NOT = IWIDTH'('h06);
    localparam logic [IWIDTH-1:0] OP_ADD = IWIDTH'('h07);
    localparam logic [IWIDTH-1:0] OP_SUB = IWIDTH'('h08);
    localparam logic [IWIDTH-1:0] OP_MUL = IWIDTH'('h09);
    localparam logic [IWIDTH-1:0] OP_DIV = IWIDTH'('h0A);
    localparam logic [IWIDTH-1:0] OP_MOD = IWIDTH'('h0B);
    localparam logic [IWIDTH-1:0] OP_GT = IWIDTH'('h0C);
    localparam logic [IWIDTH-1:0] OP_GE = IWIDTH'('h0D);
    localparam logic [IWIDTH-1:0] OP_EQ = IWIDTH'('h0E);
    localparam logic [IWIDTH-1:0] OP_NE = IWIDTH'('h0F);
    localparam logic [IWIDTH-1:0] OP_LE = IWIDTH'('h10);
    localparam logic [IWIDTH-1:0] OP_LT = IWIDTH'('h11);
    localparam logic [IWIDTH-1:0] OP_S = IWIDTH'('h1B);
    localparam logic [IWIDTH-1:0] OP_R = IWIDTH'('h1C);
    localparam logic [IWIDTH-1:0] OP_ST = IWIDTH'('h1D);
    localparam logic [IWIDTH-1:0] OP_STN = IWIDTH'('h1E);
    localparam logic [IWIDTH-1:0] OP_LD = IWIDTH'('h1F);
    localparam logic [IWIDTH-1:0] OP_LDN = IWIDTH'('h20);

    logic             accept;
    logic             is_iter;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] sc_res;
    logic             sc_cf;
    logic             sc_err;
    logic             wr_en;
    logic [WIDTH-1:0] wr_res;
    logic [WIDTH-1:0] wr_hi;
    logic             wr_cf;
    logic             wr_err;

    assign accept = start && !busy;
    assign add_s  = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, cf};
    assign sub_s  = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, cf};

    always_comb begin
        sc_res = '0;
        sc_cf  = cf;
        sc_err = 1'b0;
        case (op_code)
            OP_AND:  sc_res = in_a & in_b;
            OP_ANDN: sc_res = ~(in_a & in_b);
            OP_OR:   sc_res = in_a | in_b;
            OP_ORN:  sc_res = ~(in_a | in_b);
            OP_XOR:  sc_res = in_a ^ in_b;
            OP_XORN: sc_res = ~(in_a ^ in_b);
            OP_NOT:  sc_res = ~in_a;
            OP_ADD: begin
                sc_res = add_s[WIDTH-1:0];
                sc_cf  = add_s[WIDTH];
            end
            OP_SUB: begin
                sc_res = sub_s[WIDTH-1:0];
                sc_cf  = sub_s[WIDTH];
            end
            OP_GT:        sc_res = {WIDTH{in_a > in_b}};
            OP_GE:        sc_res = {WIDTH{in_a >= in_b}};
            OP_EQ:        sc_res = {WIDTH{in_a == in_b}};
            OP_NE:        sc_res = {WIDTH{in_a != in_b}};
            OP_LE:        sc_res = {WIDTH{in_a <= in_b}};
            OP_LT:        sc_res = {WIDTH{in_a < in_b}};
            OP_S:         sc_res = '1;
            OP_R:         sc_res = '0;
            OP_ST, OP_LD:   sc_res = in_a;
            OP_STN, OP_LDN: sc_res = ~in_a;
            default:      sc_err = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ITER = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_mul_r;
    logic             is_mod_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   m_sum;
    logic [WIDTH:0]   d_sh;
    logic [WIDTH:0]   d_diff;
    logic             d_ge;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic             it_done;
    logic [WIDTH-1:0] it_res;

    assign is_iter = (op_code == OP_MUL) || (op_code == OP_DIV) || (op_code == OP_MOD);
    assign busy    = (state == ITER);

    // MUL: {hi,lo} shifts right with lo holding the multiplier.
    // DIV: hi is the partial remainder, lo shifts quotient bits in.
    assign m_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : {(WIDTH + 1){1'b0}});
    assign d_sh   = {hi, lo[WIDTH-1]};
    assign d_diff = d_sh - {1'b0, b_r};
    assign d_ge   = ~d_diff[WIDTH];
    assign hi_n   = is_mul_r ? m_sum[WIDTH:1]
                  : (d_ge ? d_diff[WIDTH-1:0] : d_sh[WIDTH-1:0]);
    assign lo_n   = is_mul_r ? {m_sum[0], lo[WIDTH-1:1]}
                  : {lo[WIDTH-2:0], d_ge};

    assign it_done = busy && (cnt == LAST);
    assign it_res  = is_mul_r ? lo_n
                   : (b_r == '0) ? (is_mod_r ? a_r : '1)
                   : (is_mod_r ? hi_n : lo_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_mul_r <= 1'b0;
            is_mod_r <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else if (state == IDLE) begin
            if (accept && is_iter) begin
                state    <= ITER;
                cnt      <= '0;
                is_mul_r <= (op_code == OP_MUL);
                is_mod_r <= (op_code == OP_MOD);
                a_r      <= in_a;
                b_r      <= in_b;
                hi       <= '0;
                lo       <= (op_code == OP_MUL) ? in_b : in_a;
            end
        end else begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end
`else
    assign is_iter = 1'b0;
    assign busy    = 1'b0;
`endif

    always_comb begin
        wr_en  = accept && !is_iter;
        wr_res = sc_res;
        wr_hi  = '0;
        wr_cf  = sc_cf;
        wr_err = sc_err;
`ifdef ALU_MULDIV_EN
        if (it_done) begin
            wr_en  = 1'b1;
            wr_res = it_res;
            wr_hi  = is_mul_r ? hi_n : '0;
            wr_cf  = cf;
            wr_err = !is_mul_r && (b_r == '0);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            cf        <= 1'b0;
            zf        <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= wr_en;
            if (wr_en) begin
                result    <= wr_res;
                result_hi <= wr_hi;
                cf        <= wr_cf;
                zf        <= (wr_res == '0);
                err       <= wr_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=8, IWIDTH=8).
// Follows the ALU_MULDIV_EN setting of the build.
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] op_code;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       cf;
    logic       zf;
    logic       err;

    int n_chk  = 0;
    int n_pass = 0;

    alu_mc #(.WIDTH(8), .IWIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op_code(op_code),
        .in_a(in_a),
        .in_b(in_b),
        .busy(busy),
        .done(done),
        .result(result),
        .result_hi(result_hi),
        .cf(cf),
        .zf(zf),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Single-cycle op: drive at negedge, sample 1ns after the accepting edge.
    task automatic do_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start   = 1'b1;
        op_code = op;
        in_a    = a;
        in_b    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] r, input logic e);
        check({tag, ".done"}, done, 1);
        check({tag, ".res"}, result, r);
        check({tag, ".zf"}, zf, r == 8'h00);
        check({tag, ".err"}, err, e);
        check({tag, ".busy"}, busy, 0);
    endtask

`ifdef ALU_MULDIV_EN
    // Iterative op with a competing start held during the first busy cycle.
    task automatic run_iter(input string tag, input logic [7:0] op,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] er, input logic [7:0] eh,
                            input logic ee);
        int lat;
        int bcnt;
        do_op(op, a, b);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".done0"}, done, 0);
        bcnt = busy ? 1 : 0;
        lat  = 0;
        @(negedge clk);
        start   = 1'b1;
        op_code = 8'h1B;
        in_a    = 8'h00;
        in_b    = 8'h00;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
        end
        check({tag, ".lat"}, lat, 8);
        check({tag, ".bcnt"}, bcnt, 8);
        check({tag, ".res"}, result, er);
        check({tag, ".hi"}, result_hi, eh);
        check({tag, ".err"}, err, ee);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, done, 0);
    endtask
`endif

    initial begin
        int seen;
        rst     = 1'b1;
        start   = 1'b0;
        op_code = '0;
        in_a    = '0;
        in_b    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.res", result, 0);
        check("rst.hi", result_hi, 0);
        check("rst.flags", {busy, done, cf, zf, err}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'h07, 8'hF0, 8'h20);
        chk_res("add1", 8'h10, 0);
        check("add1.cf", cf, 1);
        check("add1.hi", result_hi, 0);
        do_op(8'h07, 8'h01, 8'h01);
        chk_res("add2", 8'h03, 0);
        check("add2.cf", cf, 0);
        do_op(8'h08, 8'h00, 8'h01);
        chk_res("sub", 8'hFF, 0);
        check("sub.cf", cf, 1);
        @(posedge clk);
        #1;
        check("idle.done", done, 0);
        check("idle.hold", result, 8'hFF);

        do_op(8'h0C, 8'h05, 8'h09);
        chk_res("gt", 8'h00, 0);
        do_op(8'h11, 8'h05, 8'h09);
        chk_res("lt", 8'hFF, 0);
        do_op(8'h0E, 8'h05, 8'h09);
        chk_res("eq", 8'h00, 0);
        do_op(8'h0F, 8'h05, 8'h09);
        chk_res("ne", 8'hFF, 0);
        do_op(8'h10, 8'h05, 8'h09);
        chk_res("le", 8'hFF, 0);
        do_op(8'h0D, 8'h09, 8'h09);
        chk_res("ge", 8'hFF, 0);
        check("cmp.cf", cf, 1);
        do_op(8'h3F, 8'h05, 8'h09);
        chk_res("ill", 8'h00, 1);
        check("ill.cf", cf, 1);
        do_op(8'h03, 8'hA5, 8'h0F);
        chk_res("orn", 8'h50, 0);
        do_op(8'h01, 8'hF0, 8'h3C);
        chk_res("andn", 8'hCF, 0);
        do_op(8'h05, 8'hA5, 8'h0F);
        chk_res("xorn", 8'h55, 0);
        do_op(8'h06, 8'h0F, 8'h00);
        chk_res("not", 8'hF0, 0);
        do_op(8'h1B, 8'h00, 8'h00);
        chk_res("s", 8'hFF, 0);
        do_op(8'h1C, 8'hFF, 8'hFF);
        chk_res("r", 8'h00, 0);
        do_op(8'h20, 8'h0F, 8'h00);
        chk_res("ldn", 8'hF0, 0);
        do_op(8'h1D, 8'h5A, 8'h00);
        chk_res("st", 8'h5A, 0);

`ifdef ALU_MULDIV_EN
        run_iter("mul", 8'h09, 8'h12, 8'h34, 8'hA8, 8'h03, 0);
        run_iter("div", 8'h0A, 8'hC8, 8'h07, 8'h1C, 8'h00, 0);
        run_iter("mod", 8'h0B, 8'hC8, 8'h07, 8'h04, 8'h00, 0);
        run_iter("div0", 8'h0A, 8'h05, 8'h00, 8'hFF, 8'h00, 1);
        run_iter("mod0", 8'h0B, 8'h05, 8'h00, 8'h05, 8'h00, 1);
        check("muldiv.cf", cf, 1);
        do_op(8'h09, 8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.res", result, 0);
        check("midrst.flags", {busy, done, cf, zf, err}, 0);
`else
        do_op(8'h09, 8'h12, 8'h34);
        chk_res("mul.off", 8'h00, 1);
        check("mul.off.hi", result_hi, 0);
        check("mul.off.cf", cf, 1);
        do_op(8'h0A, 8'hC8, 8'h07);
        chk_res("div.off", 8'h00, 1);
        do_op(8'h1D, 8'h77, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check("rst2.res", result, 0);
        check("rst2.flags", {busy, done, cf, zf, err}, 0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("rst.nodone", seen, 0);
        do_op(8'h00, 8'hF0, 8'h3C);
        chk_res("and", 8'h30, 0);
        check("and.cf", cf, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the CPU's combinational ALU. Accepts an opcode and two pre-selected operands through a start/busy/done handshake. Executes logic, add/sub and compare ops in one cycle, and MUL/DIV/MOD iteratively over WIDTH cycles. Holds result and flag registers for the control unit and sits between the operand source multiplexers and the accumulator/write-back path.

## Interface
- WIDTH, 8, operand/result width (≥2)
- IWIDTH, 8, opcode width (≥6)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op_code  in  IWIDTH  operation, sampled on acceptance
- in_a  in  WIDTH  operand A, sampled on acceptance
- in_b  in  WIDTH  operand B, sampled on acceptance
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: result/flags updated
- result  out  WIDTH  result register (low half for MUL)
- result_hi  out  WIDTH  high half of MUL product; 0 after any other op
- cf  out  1  carry/borrow flag register
- zf  out  1  set when result==0 at the last done
- err  out  1  set for div-by-zero, illegal or disabled op; cleared by next done

## Operation
- Opcodes (hex): 00 AND, 01 ANDN (~(a&b)), 02 OR, 03 ORN, 04 XOR, 05 XORN, 06 NOT a, 07 ADD, 08 SUB, 09 MUL, 0A DIV, 0B MOD, 0C GT, 0D GE, 0E EQ, 0F NE, 10 LE, 11 LT, 1B S (all ones), 1C R (all zeros), 1D ST / 1F LD (a), 1E STN / 20 LDN (~a).
- ADD: {cf,result} = a + b + cf. SUB: {cf,result} = a − b − cf, cf = borrow. All other ops leave cf unchanged.
- Compares are unsigned. True gives all ones, false gives all zeros, EQ/NE included.
- MUL is unsigned shift-add, one partial product per cycle. The 2·WIDTH product goes to {result_hi,result}.
- DIV/MOD is unsigned restoring division, one quotient bit per cycle.
- Divide by zero: DIV gives all ones, MOD gives a, err=1, with normal iterative latency.
- Illegal opcode: result=0, result_hi=0, err=1, single-cycle latency. cf is unchanged.
- States: IDLE, ITER.
  - IDLE→ITER on an accepted MUL/DIV/MOD.
  - ITER→IDLE when the iteration counter reaches WIDTH−1, producing done.
  - Single-cycle ops stay in IDLE.
- start while busy=1 is ignored with no side effects. The request is not queued.

## Timing
- Acceptance at edge k: start=1 and busy=0 before edge k.
- Single-cycle ops: result, flags and done=1 are valid after edge k. busy stays 0, so back-to-back starts are accepted every cycle.
- Iterative ops: busy=1 after edges k … k+WIDTH−1. done=1 and busy=0 after edge k+WIDTH. A new start is accepted in the cycle done is high.
- done is high for exactly one cycle per accepted request.
- result, result_hi, cf, zf and err hold their values between done pulses.
- Reset (asynchronous, any time, including mid-ITER) forces:
  - state=IDLE, counter=0
  - busy=0, done=0, result=0, result_hi=0, cf=0, zf=0, err=0
  - Any in-flight operation is discarded with no done.

## Configuration
- ALU_MULDIV_EN defined: MUL/DIV/MOD are implemented as above.
- ALU_MULDIV_EN undefined:
  - Iterative datapath and ITER state are not built.
  - 09/0A/0B act as illegal opcodes: done after edge k, result=0, result_hi=0, err=1.
  - busy is tied to 0.

## Test plan
- After reset: ADD F0+20 → result 10, cf=1, done after 1 edge. Next ADD 01+01 → result 03, cf=0. Then SUB 00−01 → result FF, cf=1.
- MUL 12×34 (ALU_MULDIV_EN) → result A8, result_hi 03. busy high for exactly 8 cycles, done after edge k+8. A start asserted while busy is ignored.
- DIV C8/07 → 1C; MOD C8/07 → 04; DIV 05/00 → FF with err=1; MOD 05/00 → 05 with err=1.
- Compares with a=05, b=09: GT→00, LT→FF, EQ→00, NE→FF, LE→FF. zf tracks each done. Opcode 3F → result 00, err=1, cf unchanged.
- rst pulsed mid-MUL (cycle 4) → all outputs 0 immediately, no done. A following AND F0&3C → 30 after 1 edge.
- ALU_MULDIV_EN undefined: MUL 12×34 → done after 1 edge, result 00, err=1, busy never asserted.
